// File: rtl/traffic_phase_encoder.sv
// Intersection phase controller: round-robin service of three demand sensors with
// min/max green, fixed yellow and all-red clearance. bits is the registered state code.
module traffic_phase_encoder #(
   parameter int RED_CYCLES    = 2,
   parameter int GREEN_MIN     = 5,
   parameter int GREEN_MAX     = 10,
   parameter int YELLOW_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ew_str_sensor,
   input  logic       ew_left_sensor,
   input  logic       ns_sensor,
   output logic [2:0] bits
);

   localparam int MAX_RG = (RED_CYCLES > GREEN_MIN) ? RED_CYCLES : GREEN_MIN;
   localparam int MAX_MY = (GREEN_MAX > YELLOW_CYCLES) ? GREEN_MAX : YELLOW_CYCLES;
   localparam int MAX_P  = (MAX_RG > MAX_MY) ? MAX_RG : MAX_MY;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] RED_LAST    = CW'(RED_CYCLES - 1);
   localparam logic [CW-1:0] GMIN_LAST   = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] GMAX_LAST   = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYCLES - 1);

   typedef enum logic [2:0] {
      ALL_RED = 3'b000,
      EWS_G   = 3'b001,
      EWS_Y   = 3'b010,
      EWL_G   = 3'b011,
      EWL_Y   = 3'b100,
      NS_G    = 3'b101,
      NS_Y    = 3'b110
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [1:0]      ptr_reg, ptr_next;

   logic [2:0]      req;
   logic            any_req;
   logic [1:0]      dir;
   state_t          grant_state;
   logic            own, other;
   state_t          yellow_state;

   assign req     = {ns_sensor, ew_left_sensor, ew_str_sensor};
   assign any_req = |req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ALL_RED;
         cnt_reg   <= '0;
         ptr_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign bits = state_reg;

   // First requesting direction when scanning 0->1->2 starting at ptr.
   always_comb begin
      dir = 2'd0;
      case (ptr_reg)
         2'd1:    dir = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd2:    dir = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: dir = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      grant_state = NS_G;
      case (dir)
         2'd0:    grant_state = EWS_G;
         2'd1:    grant_state = EWL_G;
         default: grant_state = NS_G;
      endcase
   end

   always_comb begin
      own          = 1'b0;
      other        = 1'b0;
      yellow_state = ALL_RED;
      case (state_reg)
         EWS_G: begin
            own          = ew_str_sensor;
            other        = ew_left_sensor | ns_sensor;
            yellow_state = EWS_Y;
         end
         EWL_G: begin
            own          = ew_left_sensor;
            other        = ew_str_sensor | ns_sensor;
            yellow_state = EWL_Y;
         end
         NS_G: begin
            own          = ns_sensor;
            other        = ew_str_sensor | ew_left_sensor;
            yellow_state = NS_Y;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         ALL_RED: begin
            // cnt parks at RED_LAST with no demand, so a late request is granted next edge.
            if (cnt_reg >= RED_LAST) begin
               cnt_next = RED_LAST;
               if (any_req) begin
                  state_next = grant_state;
                  cnt_next   = '0;
                  ptr_next   = (dir == 2'd2) ? 2'd0 : dir + 2'd1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         EWS_G, EWL_G, NS_G: begin
            if (cnt_reg < GMIN_LAST) begin
               cnt_next = cnt_reg + 1'b1;
            end else if (other && (!own || cnt_reg >= GMAX_LAST)) begin
               state_next = yellow_state;
               cnt_next   = '0;
            end else if (cnt_reg < GMAX_LAST) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         EWS_Y, EWL_Y, NS_Y: begin
            if (cnt_reg >= YELLOW_LAST) begin
               state_next = ALL_RED;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ALL_RED;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_encoder.sv
// Scoreboard bench: the driver pushes the hand-computed phase code for each cycle,
// and a negedge monitor pops and compares it against bits.
module tb_traffic_phase_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ew_str_sensor = 1'b0;
   logic       ew_left_sensor = 1'b0;
   logic       ns_sensor = 1'b0;
   logic [2:0] bits;

   logic [2:0] exp_q[$];
   string      lbl_q[$];
   int         passed = 0;
   int         total = 0;
   string      scen = "none";
   int         cyc = 0;
   logic [2:0] mon_e;
   string      mon_l;

   always #5 clk = ~clk;

   traffic_phase_encoder dut (
      .clk            (clk),
      .reset          (reset),
      .ew_str_sensor  (ew_str_sensor),
      .ew_left_sensor (ew_left_sensor),
      .ns_sensor      (ns_sensor),
      .bits           (bits)
   );

   // s = {ns, ew_left, ew_str}; e = code expected during this cycle.
   task automatic step(input logic r, input logic [2:0] s, input logic [2:0] e);
      @(posedge clk);
      #1;
      reset = r;
      {ns_sensor, ew_left_sensor, ew_str_sensor} = s;
      exp_q.push_back(e);
      lbl_q.push_back($sformatf("%s c%0d", scen, cyc));
      cyc++;
   endtask

   task automatic run(input logic [2:0] s, input logic [2:0] e, input int n);
      repeat (n) step(1'b0, s, e);
   endtask

   task automatic do_reset(input string name);
      repeat (2) begin
         @(posedge clk);
         #1;
         reset = 1'b1;
         {ns_sensor, ew_left_sensor, ew_str_sensor} = 3'b000;
      end
      scen = name;
      cyc  = 0;
   endtask

   // Monitor: bits is valid every cycle, so compare whenever an expectation is queued.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_l = lbl_q.pop_front();
            total++;
            if (bits === mon_e) begin
               passed++;
               $display("chk %s bits=%b exp=%b ok", mon_l, bits, mon_e);
            end else begin
               $display("FAIL %s: bits=%b expected=%b", mon_l, bits, mon_e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) assert (bits !== 3'b111) else $error("bits reached reserved code 111");
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      // Idle, then a late request is granted on the very next edge.
      do_reset("idle");
      run(3'b000, 3'b000, 100);
      run(3'b100, 3'b000, 1);
      run(3'b100, 3'b101, 5);

      do_reset("single_ns");
      run(3'b100, 3'b000, 2);
      run(3'b100, 3'b101, 110);

      do_reset("max_green");
      run(3'b101, 3'b000, 2);
      run(3'b101, 3'b001, 10);
      run(3'b101, 3'b010, 3);
      run(3'b101, 3'b000, 2);
      run(3'b101, 3'b101, 10);
      run(3'b101, 3'b110, 3);
      run(3'b101, 3'b000, 2);
      run(3'b101, 3'b001, 2);

      do_reset("min_green");
      run(3'b101, 3'b000, 2);
      run(3'b101, 3'b001, 2);
      run(3'b100, 3'b001, 3);
      run(3'b100, 3'b010, 3);
      run(3'b100, 3'b000, 2);
      run(3'b100, 3'b101, 20);

      do_reset("left_only");
      run(3'b010, 3'b000, 2);
      run(3'b010, 3'b011, 20);

      do_reset("round_robin");
      run(3'b111, 3'b000, 2);
      repeat (2) begin
         run(3'b111, 3'b001, 10);
         run(3'b111, 3'b010, 3);
         run(3'b111, 3'b000, 2);
         run(3'b111, 3'b011, 10);
         run(3'b111, 3'b100, 3);
         run(3'b111, 3'b000, 2);
         run(3'b111, 3'b101, 10);
         run(3'b111, 3'b110, 3);
         run(3'b111, 3'b000, 2);
      end
      run(3'b111, 3'b001, 3);

      // Reset sampled at the end of the second yellow cycle; ptr must restart at ew_str.
      do_reset("reset_mid_yellow");
      run(3'b111, 3'b000, 2);
      run(3'b111, 3'b001, 10);
      run(3'b111, 3'b010, 1);
      step(1'b1, 3'b111, 3'b010);
      run(3'b111, 3'b000, 2);
      run(3'b111, 3'b001, 3);

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         $display("FAIL drain: queued=%0d expected=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
